// File: rtl/serial_byte_tx_if.sv
// Byte handshake into serial_byte_tx: a byte moves when data_valid and
// data_ready are both high on a rising clk edge; data_in must be stable while data_valid is high.
interface serial_byte_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/serial_byte_tx.sv
// Byte-to-serial transmitter: one byte per cs_n frame, mosi stable across each
// sclk rising edge, a short hold after the last bit, then a one-cycle done pulse.
module serial_byte_tx #(
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_byte_tx_if.slave   bus,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] hcnt;
    logic [2:0] bcnt;
    logic [7:0] sreg;
    logic [7:0] sreg_next;

    assign bus.data_ready = (state == IDLE);
    assign busy           = (state != IDLE);
    assign dbg_state      = state;

    // The shift register always presents the bit on air in its leading position.
    assign sreg_next = LSB_FIRST ? {1'b0, sreg[7:1]} : {sreg[6:0], 1'b0};

    function automatic logic lead_bit(input logic [7:0] v);
        return LSB_FIRST ? v[0] : v[7];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hcnt  <= '0;
            bcnt  <= '0;
            sreg  <= '0;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            cs_n  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.data_valid) begin
                        state <= SHIFT;
                        sreg  <= bus.data_in;
                        mosi  <= lead_bit(bus.data_in);
                        cs_n  <= 1'b0;
                        sclk  <= 1'b0;
                        hcnt  <= '0;
                        bcnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (hcnt == HALF_LAST) begin
                        hcnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bcnt == 3'd7) begin
                                // Last high phase over: mosi keeps bit 8 through HOLD.
                                state <= HOLD;
                            end else begin
                                bcnt <= bcnt + 3'd1;
                                sreg <= sreg_next;
                                mosi <= lead_bit(sreg_next);
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (hcnt == HALF_LAST) begin
                        hcnt  <= '0;
                        state <= DONE;
                        cs_n  <= 1'b1;
                        done  <= 1'b1;
                        mosi  <= 1'b0;
                        sreg  <= '0;
                        bcnt  <= '0;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx: three instances (MSB-first div 4, LSB-first div 4,
// MSB-first div 1) driven with directed frames and checked cycle by cycle.
module tb_serial_byte_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] din [3];
    logic       dv  [3];
    logic       sclk_w [3];
    logic       mosi_w [3];
    logic       cs_w   [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       rdy_w  [3];
    logic [1:0] st_w   [3];

    serial_byte_tx_if if0 ();
    serial_byte_tx_if if1 ();
    serial_byte_tx_if if2 ();

    assign if0.data_in = din[0];
    assign if0.data_valid = dv[0];
    assign if1.data_in = din[1];
    assign if1.data_valid = dv[1];
    assign if2.data_in = din[2];
    assign if2.data_valid = dv[2];
    assign rdy_w[0] = if0.data_ready;
    assign rdy_w[1] = if1.data_ready;
    assign rdy_w[2] = if2.data_ready;

    serial_byte_tx #(.CLK_DIV(4), .LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .sclk(sclk_w[0]), .mosi(mosi_w[0]),
        .cs_n(cs_w[0]), .busy(busy_w[0]), .done(done_w[0]), .dbg_state(st_w[0]));
    serial_byte_tx #(.CLK_DIV(4), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .sclk(sclk_w[1]), .mosi(mosi_w[1]),
        .cs_n(cs_w[1]), .busy(busy_w[1]), .done(done_w[1]), .dbg_state(st_w[1]));
    serial_byte_tx #(.CLK_DIV(1), .LSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .sclk(sclk_w[2]), .mosi(mosi_w[2]),
        .cs_n(cs_w[2]), .busy(busy_w[2]), .done(done_w[2]), .dbg_state(st_w[2]));

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the accept edge is the next rising edge.
    // The bit sequence seen at sclk rising edges is packed first-bit-in-MSB
    // and compared against the head of exp_q.
    task automatic run_frame(input int d, input int div, input logic [7:0] val,
                             input bit keep, input logic [7:0] next_v,
                             input bit inject, input string tag);
        int cs_err = 0, sclk_err = 0, done_err = 0, rdy_err = 0, idle_err = 0, rises = 0;
        logic prev_sclk = 1'b0;
        logic [7:0] got = '0;
        logic exp_sclk;
        logic [7:0] exp_v;
        int last = 17 * div + 2;
        din[d] = val;
        dv[d]  = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            exp_sclk = (c <= 16 * div) ? 1'(((c - 1) / div) % 2) : 1'b0;
            if (sclk_w[d] !== exp_sclk) sclk_err++;
            if (cs_w[d] !== ((c >= 1 && c <= 17 * div) ? 1'b0 : 1'b1)) cs_err++;
            if (done_w[d] !== ((c == 17 * div + 1) ? 1'b1 : 1'b0)) done_err++;
            if (rdy_w[d] !== ((c == last) ? 1'b1 : 1'b0)) rdy_err++;
            if (busy_w[d] !== ((c == last) ? 1'b0 : 1'b1)) rdy_err++;
            if (c == last && mosi_w[d] !== 1'b0) idle_err++;
            if (sclk_w[d] === 1'b1 && prev_sclk === 1'b0) begin
                got = {got[6:0], mosi_w[d]};
                rises++;
            end
            prev_sclk = sclk_w[d];
            if (c == 1 && !keep) dv[d] = 1'b0;
            if (c == 3) din[d] = ~val;
            if (inject && c == 10) begin
                din[d] = 8'hFF;
                dv[d]  = 1'b1;
            end
            if (inject && c == 11) begin
                din[d] = 8'h00;
                dv[d]  = 1'b0;
            end
            if (keep && c == 17 * div + 1) din[d] = next_v;
        end
        exp_v = exp_q.pop_front();
        check({tag, "_bits"}, {24'd0, got}, {24'd0, exp_v});
        check({tag, "_rises"}, rises, 8);
        check({tag, "_sclk_pattern_errs"}, sclk_err, 0);
        check({tag, "_cs_window_errs"}, cs_err, 0);
        check({tag, "_done_errs"}, done_err, 0);
        check({tag, "_ready_busy_errs"}, rdy_err, 0);
        check({tag, "_idle_mosi_errs"}, idle_err, 0);
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_cs_n"}, {31'd0, cs_w[d]}, 1);
        check({tag, "_sclk"}, {31'd0, sclk_w[d]}, 0);
        check({tag, "_mosi"}, {31'd0, mosi_w[d]}, 0);
        check({tag, "_done"}, {31'd0, done_w[d]}, 0);
        check({tag, "_ready"}, {31'd0, rdy_w[d]}, 1);
        check({tag, "_state"}, {30'd0, st_w[d]}, 0);
    endtask

    initial begin
        int done_seen;
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            dv[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        check_idle(2, "rst2");
        rst_n = 1'b1;

        // MSB-first 0xA5: 1,0,1,0,0,1,0,1
        exp_q.push_back(8'hA5);
        run_frame(0, 4, 8'hA5, 1'b0, 8'h00, 1'b0, "a5_msb");

        // LSB-first 0x01: 1,0,0,0,0,0,0,0 packed -> 0x80
        exp_q.push_back(8'h80);
        run_frame(1, 4, 8'h01, 1'b0, 8'h00, 1'b0, "01_lsb");

        // Back-to-back 0x3C then 0xC3 with data_valid held high
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        run_frame(0, 4, 8'h3C, 1'b1, 8'hC3, 1'b0, "b2b_first");
        run_frame(0, 4, 8'hC3, 1'b0, 8'h00, 1'b0, "b2b_second");

        // 0x00 with a 0xFF pulse in cycle 10 that must be ignored
        exp_q.push_back(8'h00);
        run_frame(0, 4, 8'h00, 1'b0, 8'h00, 1'b1, "inject");
        repeat (4) @(negedge clk);
        check("ff_never_sent_cs_n", {31'd0, cs_w[0]}, 1);

        // Reset during bit 3 high phase (cycles 29..32 for div 4)
        din[0] = 8'hC7;
        dv[0]  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) dv[0] = 1'b0;
        end
        check("pre_rst_sclk", {31'd0, sclk_w[0]}, 1);
        check("pre_rst_cs_n", {31'd0, cs_w[0]}, 0);
        #2 rst_n = 1'b0;
        #1 check_idle(0, "mid_rst");
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) done_seen++;
        end
        check("mid_rst_no_done", done_seen, 0);
        rst_n = 1'b1;

        exp_q.push_back(8'h5A);
        run_frame(0, 4, 8'h5A, 1'b0, 8'h00, 1'b0, "after_rst_5a");

        // CLK_DIV=1, 0x96: 1,0,0,1,0,1,1,0, done in cycle 18
        exp_q.push_back(8'h96);
        run_frame(2, 1, 8'h96, 1'b0, 8'h00, 1'b0, "div1_96");

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
